instr_fetch32: RTL and testbench
================================

INSTR_FETCH32 -- requirements
Module: instr_fetch32

Interface
REQ-001 Parameter: ROM_AW, default 14, program-ROM word-address width; PC bits [ROM_AW+1:2] address the ROM.
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 pc_hold  input  1  1 = freeze PC, link and counter this cycle.
REQ-005 Branch  input  1  beq decoded.
REQ-006 nBranch  input  1  bne decoded.
REQ-007 Jmp  input  1  j decoded.
REQ-008 Jal  input  1  jal decoded.
REQ-009 Jrn  input  1  jr decoded.
REQ-010 Zero  input  1  ALU zero flag for the current instruction.
REQ-011 Add_result  input  32  branch target byte address from the ALU.
REQ-012 Read_data_1  input  32  rs register value, the jr target.
REQ-013 rom_dat  input  32  program-ROM read data, combinational from rom_adr.
REQ-014 rom_adr  output  ROM_AW  program-ROM word address, equal to PC[ROM_AW+1:2].
REQ-015 Instruction  output  32  current instruction, equal to rom_dat; Opcode = [31:26], Function_opcode = [5:0].
REQ-016 PC_plus_4  output  32  PC + 4, combinational.
REQ-017 opcplus4  output  32  registered link address, written by jal.
REQ-018 instr_count  output  32  count of executed (non-held) cycles since reset.

Function
REQ-019 PC SHALL be a 32-bit register; bits [1:0] SHALL always be 0.
REQ-020 PC_plus_4 SHALL be PC + 4, modulo 2^32; PC = 32'hFFFF_FFFC SHALL give 32'h0000_0000.
REQ-021 Next PC SHALL follow this fixed priority:
- Jrn: {Read_data_1[31:2],2'b00}.
- Jmp or Jal: {PC_plus_4[31:28], Instruction[25:0], 2'b00}.
- (Branch & Zero) | (nBranch & ~Zero): {Add_result[31:2],2'b00}.
- Otherwise: PC_plus_4.
REQ-022 Branch with Zero=0, or nBranch with Zero=1, SHALL select PC_plus_4.
REQ-023 When reset=1 and pc_hold=0, PC SHALL load next PC on each rising edge; effective latency is one cycle.
REQ-024 On a rising edge with Jal=1 and pc_hold=0, opcplus4 SHALL load PC_plus_4; otherwise opcplus4 SHALL hold.
REQ-025 instr_count SHALL increment by 1 on each rising edge with pc_hold=0, wrapping 32'hFFFF_FFFF to 0.
REQ-026 With pc_hold=1, PC, opcplus4 and instr_count SHALL hold; Instruction SHALL keep reflecting the held PC.
REQ-027 Control inputs SHALL only be sampled at the clock edge; glitches between edges SHALL have no effect.
REQ-028 rom_adr SHALL truncate PC above bit ROM_AW+1, so the address wraps modulo ROM size.

Reset
REQ-029 On a rising edge with reset=0: PC=0, opcplus4=0, instr_count=0, overriding pc_hold and all controls.
REQ-030 During reset, rom_adr SHALL be 0 and PC_plus_4 SHALL be 32'h4 from the first post-reset-edge cycle.
REQ-031 Reset asserted mid-program SHALL discard any pending jump or branch; the first instruction after release SHALL be fetched from address 0.

Verification
REQ-032 Sequential fetch: reset, release, no controls for 3 edges -> PC 0,4,8,C; rom_adr 0,1,2,3; instr_count=3.
REQ-033 Branch: PC=0x10, Branch=1, Zero=1, Add_result=0x40 -> PC=0x40; same with Zero=0 -> PC=0x14; nBranch=1, Zero=0, Add_result=0x41 -> PC=0x40.
REQ-034 Jal: PC=0x20, Instruction=32'h0C00_0010, Jal=1 -> PC=0x40, opcplus4=0x24; then Jrn=1, Read_data_1=0x24 -> PC=0x24.
REQ-035 Priority: Jrn=1, Jmp=1, Branch=1, Zero=1, all at once -> PC = Read_data_1 with bits [1:0] cleared.
REQ-036 Hold and reset: pc_hold=1 for 2 edges at PC=0x8 -> PC, count and opcplus4 unchanged; reset=0 with pc_hold=1 -> PC=0, count=0, opcplus4=0.
REQ-037 Wrap: force PC=0xFFFF_FFFC, no controls -> PC=0, rom_adr=0.

Source files
------------

// File: rtl/instr_fetch32.sv
// Instruction fetch stage: 32-bit PC with jr/j/jal/beq/bne next-PC selection,
// jal link register, executed-cycle counter and a combinational program-ROM port.
module instr_fetch32 #(
    parameter int ROM_AW = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pc_hold,
    input  logic              Branch,
    input  logic              nBranch,
    input  logic              Jmp,
    input  logic              Jal,
    input  logic              Jrn,
    input  logic              Zero,
    input  logic [31:0]       Add_result,
    input  logic [31:0]       Read_data_1,
    input  logic [31:0]       rom_dat,
    output logic [ROM_AW-1:0] rom_adr,
    output logic [31:0]       Instruction,
    output logic [31:0]       PC_plus_4,
    output logic [31:0]       opcplus4,
    output logic [31:0]       instr_count
);

    logic [31:0] r_pc;
    logic [31:0] r_link;
    logic [31:0] r_count;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus_4;
    logic        w_take_branch;

    assign w_pc_plus_4   = r_pc + 32'd4;
    assign w_take_branch = (Branch & Zero) | (nBranch & ~Zero);

    always_comb begin
        w_next_pc = w_pc_plus_4;
        if (Jrn) begin
            w_next_pc = {Read_data_1[31:2], 2'b00};
        end else if (Jmp || Jal) begin
            w_next_pc = {w_pc_plus_4[31:28], rom_dat[25:0], 2'b00};
        end else if (w_take_branch) begin
            w_next_pc = {Add_result[31:2], 2'b00};
        end
    end

    // Reset dominates pc_hold; hold freezes all architectural state together.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pc    <= 32'd0;
            r_link  <= 32'd0;
            r_count <= 32'd0;
        end else if (!pc_hold) begin
            r_pc    <= w_next_pc;
            r_count <= r_count + 32'd1;
            if (Jal) begin
                r_link <= w_pc_plus_4;
            end
        end
    end

    assign rom_adr     = r_pc[ROM_AW+1:2];
    assign Instruction = rom_dat;
    assign PC_plus_4   = w_pc_plus_4;
    assign opcplus4    = r_link;
    assign instr_count = r_count;

endmodule

// File: tb/tb_instr_fetch32.sv
// Randomized and directed bench for instr_fetch32 against a behavioural
// PC/link/counter model; ROM contents are a fixed function of the word address.
module tb_instr_fetch32;

    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset, pc_hold, Branch, nBranch, Jmp, Jal, Jrn, Zero;
    logic [31:0]   Add_result, Read_data_1, rom_dat;
    logic [AW-1:0] rom_adr;
    logic [31:0]   Instruction, PC_plus_4, opcplus4, instr_count;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_pc, m_link, m_cnt;

    instr_fetch32 #(.ROM_AW(AW)) dut (
        .clock(clock), .reset(reset), .pc_hold(pc_hold),
        .Branch(Branch), .nBranch(nBranch), .Jmp(Jmp), .Jal(Jal), .Jrn(Jrn),
        .Zero(Zero), .Add_result(Add_result), .Read_data_1(Read_data_1),
        .rom_dat(rom_dat), .rom_adr(rom_adr), .Instruction(Instruction),
        .PC_plus_4(PC_plus_4), .opcplus4(opcplus4), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] rom_fn(input logic [AW-1:0] a);
        if (a == 14'd8) return 32'h0C00_0010;
        return {a, a[7:0], a[9:0]} ^ 32'hA5A5_0F0F;
    endfunction

    assign rom_dat = rom_fn(rom_adr);

    task automatic clear_ctl();
        reset = 1'b1; pc_hold = 1'b0; Branch = 1'b0; nBranch = 1'b0;
        Jmp = 1'b0; Jal = 1'b0; Jrn = 1'b0; Zero = 1'b0;
        Add_result = 32'd0; Read_data_1 = 32'd0;
    endtask

    // Advance the model by one edge from the current inputs, clock the DUT, compare.
    task automatic step(input string name);
        logic [31:0] instr, nxt;
        instr = rom_fn(m_pc[AW+1:2]);
        if (Jrn)                                nxt = Read_data_1 & ~32'd3;
        else if (Jmp || Jal)                    nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'd0, instr[25:0]} << 2);
        else if ((Branch && Zero) || (nBranch && !Zero)) nxt = Add_result & ~32'd3;
        else                                    nxt = m_pc + 32'd4;
        if (!reset) begin
            m_pc = 0; m_link = 0; m_cnt = 0;
        end else if (!pc_hold) begin
            if (Jal) m_link = m_pc + 32'd4;
            m_pc = nxt;
            m_cnt = m_cnt + 32'd1;
        end
        @(posedge clock);
        #1;
        tests++;
        if (PC_plus_4 !== m_pc + 32'd4) begin
            fails++; $display("FAIL %s pc_plus_4: got %h exp %h", name, PC_plus_4, m_pc + 32'd4);
        end
        tests++;
        if (rom_adr !== m_pc[AW+1:2]) begin
            fails++; $display("FAIL %s rom_adr: got %h exp %h", name, rom_adr, m_pc[AW+1:2]);
        end
        tests++;
        if (Instruction !== rom_fn(m_pc[AW+1:2])) begin
            fails++; $display("FAIL %s instruction: got %h exp %h", name, Instruction, rom_fn(m_pc[AW+1:2]));
        end
        tests++;
        if (opcplus4 !== m_link) begin
            fails++; $display("FAIL %s opcplus4: got %h exp %h", name, opcplus4, m_link);
        end
        tests++;
        if (instr_count !== m_cnt) begin
            fails++; $display("FAIL %s instr_count: got %h exp %h", name, instr_count, m_cnt);
        end
        @(negedge clock);
    endtask

    task automatic jump_to(input logic [31:0] target);
        clear_ctl(); Jrn = 1'b1; Read_data_1 = target;
        step("jump_to");
        clear_ctl();
    endtask

    task automatic test_reset();
        clear_ctl(); reset = 1'b0; pc_hold = 1'b1; Jmp = 1'b1; Branch = 1'b1; Zero = 1'b1;
        step("reset1");
        step("reset2");
        tests++;
        if (PC_plus_4 !== 32'h4 || rom_adr !== '0 || instr_count !== 32'd0 || opcplus4 !== 32'd0) begin
            fails++; $display("FAIL reset_state: pc4=%h adr=%h cnt=%h link=%h exp 4/0/0/0",
                              PC_plus_4, rom_adr, instr_count, opcplus4);
        end
        clear_ctl();
    endtask

    task automatic test_sequential();
        clear_ctl(); reset = 1'b0; step("seq_reset"); clear_ctl();
        for (int i = 0; i < 3; i++) step("seq");
        tests++;
        if (PC_plus_4 !== 32'h10 || rom_adr !== 14'd3 || instr_count !== 32'd3) begin
            fails++; $display("FAIL seq_end: pc4=%h adr=%h cnt=%h exp 10/3/3", PC_plus_4, rom_adr, instr_count);
        end
    endtask

    task automatic test_branch();
        jump_to(32'h10);
        Branch = 1'b1; Zero = 1'b1; Add_result = 32'h40; step("beq_taken");
        tests++;
        if (PC_plus_4 !== 32'h44) begin fails++; $display("FAIL beq_taken_pc: got %h exp 44", PC_plus_4); end
        jump_to(32'h10);
        Branch = 1'b1; Zero = 1'b0; Add_result = 32'h40; step("beq_not_taken");
        tests++;
        if (PC_plus_4 !== 32'h18) begin fails++; $display("FAIL beq_not_taken_pc: got %h exp 18", PC_plus_4); end
        jump_to(32'h10);
        nBranch = 1'b1; Zero = 1'b0; Add_result = 32'h41; step("bne_taken");
        tests++;
        if (PC_plus_4 !== 32'h44) begin fails++; $display("FAIL bne_taken_pc: got %h exp 44", PC_plus_4); end
        jump_to(32'h10);
        nBranch = 1'b1; Zero = 1'b1; Add_result = 32'h40; step("bne_not_taken");
        clear_ctl();
    endtask

    task automatic test_jal();
        jump_to(32'h20);
        Jal = 1'b1; step("jal");
        tests++;
        if (PC_plus_4 !== 32'h44 || opcplus4 !== 32'h24) begin
            fails++; $display("FAIL jal_target: pc4=%h link=%h exp 44/24", PC_plus_4, opcplus4);
        end
        clear_ctl(); Jrn = 1'b1; Read_data_1 = 32'h24; step("jr_return");
        tests++;
        if (PC_plus_4 !== 32'h28) begin fails++; $display("FAIL jr_return_pc: got %h exp 28", PC_plus_4); end
        clear_ctl();
    endtask

    task automatic test_priority();
        clear_ctl(); Jrn = 1'b1; Jmp = 1'b1; Branch = 1'b1; Zero = 1'b1;
        Read_data_1 = 32'h0000_0057; Add_result = 32'h80;
        step("priority");
        tests++;
        if (PC_plus_4 !== 32'h58) begin fails++; $display("FAIL priority_pc: got %h exp 58", PC_plus_4); end
        clear_ctl(); Jmp = 1'b1; Branch = 1'b1; Zero = 1'b1; Add_result = 32'h80;
        step("jmp_over_branch");
        clear_ctl();
    endtask

    task automatic test_hold();
        logic [31:0] cnt0, link0;
        jump_to(32'h8);
        cnt0 = m_cnt; link0 = m_link;
        pc_hold = 1'b1; Jal = 1'b1; Jrn = 1'b1; Read_data_1 = 32'h100;
        step("hold1");
        step("hold2");
        tests++;
        if (PC_plus_4 !== 32'hC || instr_count !== cnt0 || opcplus4 !== link0) begin
            fails++; $display("FAIL hold_state: pc4=%h cnt=%h link=%h exp c/%h/%h",
                              PC_plus_4, instr_count, opcplus4, cnt0, link0);
        end
        reset = 1'b0;
        step("reset_with_hold");
        tests++;
        if (PC_plus_4 !== 32'h4 || instr_count !== 0 || opcplus4 !== 0) begin
            fails++; $display("FAIL reset_with_hold: pc4=%h cnt=%h link=%h exp 4/0/0", PC_plus_4, instr_count, opcplus4);
        end
        clear_ctl();
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC);
        tests++;
        if (PC_plus_4 !== 32'h0 || rom_adr !== 14'h3FFF) begin
            fails++; $display("FAIL wrap_top: pc4=%h adr=%h exp 0/3fff", PC_plus_4, rom_adr);
        end
        step("wrap");
        tests++;
        if (PC_plus_4 !== 32'h4 || rom_adr !== '0) begin
            fails++; $display("FAIL wrap_zero: pc4=%h adr=%h exp 4/0", PC_plus_4, rom_adr);
        end
    endtask

    // Inputs glitch right after the falling edge, then settle before the rising edge.
    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            Jrn = 1'($urandom); Jmp = 1'($urandom); Jal = 1'($urandom); pc_hold = 1'($urandom);
            reset = 1'b0; Read_data_1 = $urandom;
            #1;
            clear_ctl();
            reset   = ($urandom_range(0, 31) != 0);
            pc_hold = ($urandom_range(0, 3) == 0);
            Jrn     = ($urandom_range(0, 7) == 0);
            Jmp     = ($urandom_range(0, 7) == 0);
            Jal     = ($urandom_range(0, 7) == 0);
            Branch  = ($urandom_range(0, 3) == 0);
            nBranch = ($urandom_range(0, 3) == 0);
            Zero    = 1'($urandom);
            Add_result  = $urandom;
            Read_data_1 = $urandom;
            step("random");
        end
        clear_ctl();
    endtask

    initial begin
        clear_ctl();
        @(negedge clock);
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_priority();
        test_hold();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
